// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The op encoding matches the EX-stage ALU request field.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int CNT_W     = $clog2(MDU_WIDTH);

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } mdu_state_e;

   // Bit 0 clear selects the signed variant (MULT, DIV).
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Purely combinational; the caller registers acc_out every ITER cycle.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      // Multiply: upper half accumulates the multiplicand, multiplier shifts out of the bottom.
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
                (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
      shifted = acc_in[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, operand};
      if (is_div) begin
         if (!diff[WIDTH]) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; result and done 35 cycles after start (WIDTH=32).
// No queueing: start is taken only in IDLE or the DONE cycle, flush aborts, MTHI/MTLO ignored while busy.
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = CNT_W + 1;

   mdu_state_e         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, opd_q, opd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

   logic               sgn_a, sgn_b, accept;
   logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
   logic [2*WIDTH-1:0] prod;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (op_q[1]),
      .acc_in  (acc_q),
      .operand (opd_q),
      .acc_out (step_acc)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      opd_d   = opd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      sgn_a  = op_is_signed(op_q) & opa_q[WIDTH-1];
      sgn_b  = op_is_signed(op_q) & opb_q[WIDTH-1];
      mag_a  = sgn_a ? -opa_q : opa_q;
      mag_b  = sgn_b ? -opb_q : opb_q;
      prod   = neg_q  ? -acc_q : acc_q;
      quo    = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      accept = start & ((state_q == S_IDLE) | (state_q == S_DONE));

      if (!busy_q) begin
         if (hi_we) hi_d = wdata;
         if (lo_we) lo_d = wdata;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               state_d = S_PREP;
               op_d    = op;
               opa_d   = op_a;
               opb_d   = op_b;
            end
         end
         S_PREP: begin
            state_d = S_ITER;
            cnt_d   = CW'(WIDTH);
            neg_d   = sgn_a ^ sgn_b;
            rneg_d  = sgn_a;
            dz_d    = op_q[1] & (opb_q == '0);
            if (op_q[1]) begin
               opd_d = mag_b;
               acc_d = {{WIDTH{1'b0}}, mag_a};
            end else begin
               opd_d = mag_a;
               acc_d = {{WIDTH{1'b0}}, mag_b};
            end
         end
         S_ITER: begin
            acc_d = step_acc;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            if (!op_q[1]) begin
               {hi_d, lo_d} = prod;
            end else if (dz_q) begin
               hi_d = opa_q;
               lo_d = {WIDTH{1'b1}};
            end else begin
               hi_d = rem;
               lo_d = quo;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An abort in FIX must not let the half-finished result reach HI/LO.
      if (flush) begin
         state_d = S_IDLE;
         if (state_q == S_FIX) begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
      end

      busy_d = (state_d == S_PREP) | (state_d == S_ITER) | (state_d == S_FIX);
      done_d = (state_d == S_DONE);
      dbz_d  = (state_d == S_DONE) & dz_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         opd_q   <= opd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: vector table for results and latency, hand sequences for
// flush, reset, MTHI/MTLO and back-to-back issue.
module tb_mdu_iterative;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] op_a = '0, op_b = '0, wdata = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[12];

   mdu_iterative #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op and follow it to its done pulse, checking latency, result and pulse width.
   task automatic run_op(input int idx, input vec_t v);
      int lat;
      @(posedge clk); #1;
      start = 1'b1; op = v.op; op_a = v.a; op_b = v.b;
      @(posedge clk); #1;
      start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
      check($sformatf("v%0d busy_c1", idx), {31'd0, busy}, 32'd1);
      lat = 1;
      repeat (60) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", idx), lat, 32'd35);
      check($sformatf("v%0d hi", idx), hi, v.hi);
      check($sformatf("v%0d lo", idx), lo, v.lo);
      check($sformatf("v%0d dbz", idx), {31'd0, div_by_zero}, {31'd0, v.dbz});
      check($sformatf("v%0d busy_done", idx), {31'd0, busy}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d done_pulse", idx), {30'd0, done, div_by_zero}, 32'd0);
   endtask

   initial begin
      int  g;
      logic seen;

      vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{MDU_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
      vecs[4]  = '{MDU_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[5]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6]  = '{MDU_MULT,  32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      vecs[7]  = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[8]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
      vecs[9]  = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
      vecs[10] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      check("rst flags", {29'd0, busy, done, div_by_zero}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_op(i, vecs[i]);

      // MTHI / MTLO while idle
      @(posedge clk); #1;
      hi_we = 1'b1; wdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2468_ACE0;
      @(posedge clk); #1;
      lo_we = 1'b0;
      check("mthi", hi, 32'h1357_9BDF);
      check("mtlo", lo, 32'h2468_ACE0);

      // Start at 0, ignored start + MTHI at 10, flush at 20
      start = 1'b1; op = MDU_MULTU; op_a = 32'd9; op_b = 32'd9;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         start = (c == 10);
         hi_we = (c == 10);
         wdata = 32'h1111_1111;
         flush = (c == 20);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy_c21", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("flush no_done", {31'd0, seen}, 32'd0);
      check("flush hi_kept", hi, 32'h1357_9BDF);
      check("flush lo_kept", lo, 32'h2468_ACE0);
      @(posedge clk); #1;
      lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      lo_we = 1'b0;
      check("mtlo after flush", lo, 32'hA5A5_A5A5);
      check("hi after mtlo", hi, 32'h1357_9BDF);

      // Flush and start together: start dropped
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start busy", {31'd0, busy}, 32'd0);

      // Reset at cycle 15 of a MULT
      start = 1'b1; op = MDU_MULT; op_a = 32'd5; op_b = 32'd6;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         rst = (c == 15);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst hi", hi, 32'd0);
      check("midrst lo", lo, 32'd0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("midrst no_done", {31'd0, seen}, 32'd0);

      // Back-to-back: start held high; MTLO alongside the first accepted start
      @(posedge clk); #1;
      start = 1'b1; op = MDU_MULTU; op_a = 32'd3; op_b = 32'd5;
      lo_we = 1'b1; wdata = 32'h5555_5555;
      @(posedge clk); #1;
      lo_we = 1'b0; op_a = 32'd7;
      check("wr_with_start lo", lo, 32'h5555_5555);
      g = 1;
      repeat (60) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
         g++;
      end
      check("b2b first latency", g, 32'd35);
      check("b2b first lo", lo, 32'd15);
      g = 0;
      repeat (60) begin
         @(posedge clk); #1;
         g++;
         @(negedge clk);
         if (done) break;
      end
      start = 1'b0; flush = 1'b1;
      check("b2b gap", g, 32'd35);
      check("b2b second hi", hi, 32'd0);
      check("b2b second lo", lo, 32'd35);
      @(posedge clk); #1;
      flush = 1'b0;
      check("b2b idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
